// File: rtl/rs_alu_seq_ctrl_pkg.sv
// Shared types and helpers for the wide add/subtract sequencer.
package rs_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Chunk index width; a single-chunk build still needs a 1-bit index.
    function automatic int idxWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rs_alu_seq_ctrl_if.sv
// Request/response bundle between an arithmetic requester and the sequencer.
interface rs_alu_seq_ctrl_if #(
    parameter int W = 64
);
    logic         req_valid;
    logic         req_ready;
    logic         req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_ci;
    logic         abort;
    logic         busy;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_co;
    logic         rsp_ovf;

    modport master (
        output req_valid, req_op, req_a, req_b, req_ci, abort, rsp_ready,
        input  req_ready, busy, rsp_valid, rsp_sum, rsp_co, rsp_ovf
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_ci, abort, rsp_ready,
        output req_ready, busy, rsp_valid, rsp_sum, rsp_co, rsp_ovf
    );
endinterface

// File: rtl/rs_alu_seq_ctrl_chunk_adder.sv
// One CHUNK-bit ripple slice of the shared adder_carry chain.
module rs_chunk_adder #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] y,
    output logic             co,
    output logic             co_msb_in
);
    logic [CHUNK:0] w_carry;

    assign w_carry[0] = ci;

    generate
        for (genvar i = 0; i < CHUNK; i++) begin : g_bit
            assign y[i]           = a[i] ^ b[i] ^ w_carry[i];
            assign w_carry[i + 1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign co        = w_carry[CHUNK];
    // Carry into the top bit, needed by the sequencer for signed overflow.
    assign co_msb_in = w_carry[CHUNK-1];

endmodule

// File: rtl/rs_alu_seq_ctrl.sv
// Multi-cycle wide add/subtract: walks a narrow ripple slice LSB-first, one chunk per cycle.
module rs_alu_seq_ctrl
    import rs_alu_pkg::*;
#(
    parameter int CHUNK  = 16,
    parameter int NCHUNK = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    rs_alu_seq_ctrl_if.slave   bus
);
    localparam int W    = CHUNK * NCHUNK;
    localparam int IDXW = idxWidth(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    state_t          r_state;
    logic [IDXW-1:0] r_idx;
    logic            r_carry;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic            r_co;
    logic            r_ovf;

    logic [CHUNK-1:0] w_sliceA;
    logic [CHUNK-1:0] w_sliceB;
    logic [CHUNK-1:0] w_sliceY;
    logic             w_chunkCo;
    logic             w_msbIn;

    assign w_sliceA = r_a[r_idx*CHUNK +: CHUNK];
    assign w_sliceB = r_b[r_idx*CHUNK +: CHUNK];

    rs_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a         (w_sliceA),
        .b         (w_sliceB),
        .ci        (r_carry),
        .y         (w_sliceY),
        .co        (w_chunkCo),
        .co_msb_in (w_msbIn)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_a     <= bus.req_a;
                        // Subtract is A + ~B + 1; req_ci does not apply.
                        r_b     <= (bus.req_op == OP_SUB) ? ~bus.req_b : bus.req_b;
                        r_carry <= (bus.req_op == OP_SUB) ? 1'b1 : bus.req_ci;
                        r_idx   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                    end else begin
                        r_sum[r_idx*CHUNK +: CHUNK] <= w_sliceY;
                        r_carry <= w_chunkCo;
                        if (r_idx == LAST_IDX) begin
                            r_co    <= w_chunkCo;
                            r_ovf   <= w_chunkCo ^ w_msbIn;
                            r_state <= DONE;
                        end else begin
                            r_idx <= r_idx + IDXW'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.abort || bus.rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.rsp_valid = (r_state == DONE);
    assign bus.rsp_sum   = r_sum;
    assign bus.rsp_co    = r_co;
    assign bus.rsp_ovf   = r_ovf;

endmodule

// File: doc/rs_alu_seq_ctrl.md
Name: rs_alu_seq_ctrl

Overview:
- Multi-cycle sequencer for wide add/subtract on a narrow carry-chain adder.
- Accepts a W-bit request, walks a CHUNK-bit ripple adder through NCHUNK slices LSB-first, and carries the inter-chunk carry in a register.
- Returns sum, carry-out and signed overflow over a valid/ready response channel.
- Sits between arithmetic requesters and one shared adder_carry chain, so wide operands do not need a full-width chain.

Parameters:
- CHUNK, 16, slice width in bits; must be >= 3.
- NCHUNK, 4, number of slices; must be >= 1.
- W (localparam), CHUNK*NCHUNK, operand/result width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_op  input  1  0 = add, 1 = subtract (A - B).
- req_a  input  W  operand A.
- req_b  input  W  operand B.
- req_ci  input  1  carry-in for add; ignored for subtract.
- abort  input  1  synchronous cancel of the operation in flight.
- busy  output  1  high in RUN or DONE.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_sum  output  W  result.
- rsp_co  output  1  carry out of bit W-1; for subtract, 1 = no borrow.
- rsp_ovf  output  1  two's-complement overflow.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst_n low, asynchronous) forces:
  - state IDLE, chunk index 0, carry register 0, result register 0;
  - rsp_valid 0, rsp_sum 0, rsp_co 0, rsp_ovf 0, busy 0;
  - req_ready 1, because req_ready = (state == IDLE).
- IDLE, on req_valid && req_ready:
  - latch A, and B, or ~B when req_op = 1;
  - carry register <= req_op ? 1 : req_ci;
  - idx <= 0; go to RUN.
- RUN, one chunk per cycle:
  - slice [idx*CHUNK +: CHUNK] = A_slice + B_slice + carry; sum stored into the result register slice;
  - carry register <= chunk carry-out;
  - idx increments; no wrap within an operation.
- Final chunk (idx == NCHUNK-1):
  - rsp_co <= chunk carry-out;
  - rsp_ovf <= carry into bit W-1 XOR carry out of bit W-1;
  - go to DONE.
- Latency: rsp_valid rises exactly NCHUNK cycles after the accepting edge.
- DONE:
  - rsp_valid = 1; rsp_sum, rsp_co, rsp_ovf held stable until rsp_valid && rsp_ready, then IDLE.
  - req_ready is 0 in RUN and DONE. A new request is accepted no earlier than the cycle after the response handshake; no same-cycle turnaround.
- abort:
  - in RUN or DONE: next state IDLE, rsp_valid low next cycle, no response for that request;
  - in DONE, abort has priority over rsp_ready;
  - in IDLE: ignored, and a simultaneous request is accepted.
- Inputs: req_a, req_b, req_op, req_ci are sampled only at acceptance; changes during RUN have no effect.
- Result: arithmetic is modulo 2^W. rsp_sum retains its last value after the handshake and is overwritten slice-by-slice by the next operation.
- NCHUNK = 1: RUN lasts one cycle; latency 1.
- Reset mid-operation: immediate return to the reset values above, with no response.

Decomposition:
- Shared package rs_alu_pkg:
  - state enum {IDLE, RUN, DONE};
  - OP_ADD = 1'b0, OP_SUB = 1'b1;
  - index width function clog2(NCHUNK) with a minimum of 1.
- Sub-module rs_chunk_adder, purely combinational:
  - parameter CHUNK; inputs a, b, ci; outputs y[CHUNK-1:0], co, co_msb_in (carry into the top bit, used for overflow);
  - built from the adder_carry chain.
- The sequencer owns all registers and the FSM.

Test Plan:
- All tests use CHUNK=4, NCHUNK=2, W=8.
- add 0xFF + 0x01, ci=0, rsp_ready=1 -> rsp_valid exactly 2 cycles after accept; rsp_sum=0x00, rsp_co=1, rsp_ovf=0; req_ready 1 the following cycle.
- add 0x0F + 0x00, ci=1 -> 0x10, co=0, ovf=0 (carry crosses the chunk boundary). Then add 0x7F + 0x01 -> 0x80, co=0, ovf=1.
- sub 0x80 - 0x01 -> 0x7F, co=1, ovf=1. Then sub 0x00 - 0x01 -> 0xFF, co=0, ovf=0. Both with req_ci=1 to prove it is ignored.
- Backpressure:
  - stimulus: rsp_ready=0 for 5 cycles in DONE; a second req_valid held high with changing req_a;
  - response: outputs stable, req_ready=0, busy=1; the second request is accepted only on the cycle after the handshake, and the first result is unaffected.
- Abort and reset:
  - abort in the first RUN cycle -> no rsp_valid, req_ready=1 next cycle, the next request computes correctly (0x12 + 0x34 -> 0x46);
  - abort and rsp_ready together in DONE -> response dropped, IDLE;
  - rst_n low mid-RUN -> all outputs at their reset values asynchronously.
